// File: rtl/spi_cmd_regs_pkg.sv
// spi_cmd_regs_pkg: shared constants, types and helpers for the SPI view/colour register block.
// Optional colour command is enabled with the SPI_COLOUR_REGS_EN macro (see spi_cmd_regs.sv).
package spi_cmd_regs_pkg;

  // Fixed-point format of the view vectors: Q6.9, so 1.0 is 1 << 9.
  localparam int unsigned FW_DEFAULT = 16;
  localparam int unsigned FRAC_BITS  = 9;
  localparam logic [15:0] FX_ONE     = 16'(1 << FRAC_BITS);

  // Command byte and payload geometry.
  localparam int unsigned CMD_BITS    = 8;
  localparam logic [7:0]  CMD_VIEW    = 8'h00;
  localparam logic [7:0]  CMD_COLOUR  = 8'h01;
  localparam int unsigned VIEW_VECS   = 6;
  localparam int unsigned COLOUR_W    = 6;
  localparam int unsigned COLOUR_BITS = 2 * COLOUR_W;

  // Power-on view: player at (1.5, 1.5) facing +Y, camera plane along -X.
  localparam logic [15:0] RST_PLAYER_X = 16'h0300;
  localparam logic [15:0] RST_PLAYER_Y = 16'h0300;
  localparam logic [15:0] RST_FACING_X = 16'h0000;
  localparam logic [15:0] RST_FACING_Y = FX_ONE;
  localparam logic [15:0] RST_VPLANE_X = 16'hFF00;
  localparam logic [15:0] RST_VPLANE_Y = 16'h0000;

  // Power-on background colours (2 bits per channel).
  localparam logic [COLOUR_W-1:0] RST_SKY   = 6'b01_01_01;
  localparam logic [COLOUR_W-1:0] RST_FLOOR = 6'b10_10_10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } spi_state_e;

  typedef enum logic {
    PL_VIEW   = 1'b0,
    PL_COLOUR = 1'b1
  } payload_kind_e;

  // Colour payload as it arrives on the wire: sky first, then floor.
  typedef struct packed {
    logic [COLOUR_W-1:0] sky;
    logic [COLOUR_W-1:0] flr;
  } colour_t;

  // Number of payload bits carried by the view command for a given vector width.
  function automatic int unsigned view_bits(input int unsigned fw);
    return VIEW_VECS * fw;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchronisers for the SPI pins plus registered sclk-rise
// and ss_n fall/rise pulses in the clk domain. All outputs are registered and aligned,
// so mosi_o holds the bit that belongs to a sclk_rise_o pulse in the same cycle.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic ss_n_i,
  output logic sclk_rise_o,
  output logic mosi_o,
  output logic ss_n_o,
  output logic ss_fall_o,
  output logic ss_rise_o
);

  logic [1:0] sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic [1:0] ss_sync_q;
  logic       sclk_prev_q;
  logic       ss_prev_q;
  logic [1:0] prime_q;

  // Synchronise, then form edge pulses. ss_prev_q is held low until the synchroniser
  // holds real samples, so a select already low when reset drops never looks like a
  // fresh falling edge: the bus must be seen idle (high) before a transaction can start.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      ss_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      prime_q     <= 2'b00;
      sclk_rise_o <= 1'b0;
      mosi_o      <= 1'b0;
      ss_n_o      <= 1'b1;
      ss_fall_o   <= 1'b0;
      ss_rise_o   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      ss_sync_q   <= {ss_sync_q[0], ss_n_i};
      prime_q     <= {prime_q[0], 1'b1};
      sclk_prev_q <= sclk_sync_q[1];
      ss_prev_q   <= prime_q[1] ? ss_sync_q[1] : 1'b0;
      sclk_rise_o <= sclk_sync_q[1] & ~sclk_prev_q;
      mosi_o      <= mosi_sync_q[1];
      ss_n_o      <= ss_sync_q[1];
      ss_fall_o   <= ss_prev_q & ~ss_sync_q[1];
      ss_rise_o   <= ss_sync_q[1] & ~ss_prev_q;
    end
  end

endmodule

// File: rtl/spi_cmd_regs.sv
// spi_cmd_regs: SPI mode-0 slave that receives view vectors (and, with macro
// SPI_COLOUR_REGS_EN defined, background colours) into shadow registers and commits
// them to the live outputs on load_if_ready, i.e. only between visible frames.
module spi_cmd_regs
  import spi_cmd_regs_pkg::*;
#(
  parameter int unsigned FW = FW_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_sclk,
  input  logic                i_mosi,
  input  logic                i_ss_n,
  input  logic                load_if_ready,
  output logic [FW-1:0]       playerX,
  output logic [FW-1:0]       playerY,
  output logic [FW-1:0]       facingX,
  output logic [FW-1:0]       facingY,
  output logic [FW-1:0]       vplaneX,
  output logic [FW-1:0]       vplaneY,
  output logic [COLOUR_W-1:0] sky_rgb,
  output logic [COLOUR_W-1:0] floor_rgb,
  output logic                o_loaded,
  output logic                o_busy
);

  localparam int unsigned VIEW_LEN = view_bits(FW);
  localparam int unsigned SR_W     = VIEW_LEN;
  localparam int unsigned CNT_W    = $clog2(VIEW_LEN + 1);

  logic sclk_rise;
  logic mosi_s;
  logic ss_n_s;
  logic ss_fall;
  logic ss_rise;

  spi_state_e          state_q;
  payload_kind_e       kind_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CMD_BITS-2:0] cmd_q;
  logic [SR_W-2:0]     sr_q;

  logic [SR_W-1:0]     view_shadow_q;
  logic                view_pend_q;

  logic [CMD_BITS-1:0] cmd_shift_c;
  logic [SR_W-1:0]     sr_shift_c;
  logic                payload_last_c;
  logic                complete_c;
  logic                view_done_c;
  logic                any_pend_c;

  spi_sync_edge u_sync (
    .clk         (clk),
    .reset       (reset),
    .sclk_i      (i_sclk),
    .mosi_i      (i_mosi),
    .ss_n_i      (i_ss_n),
    .sclk_rise_o (sclk_rise),
    .mosi_o      (mosi_s),
    .ss_n_o      (ss_n_s),
    .ss_fall_o   (ss_fall),
    .ss_rise_o   (ss_rise)
  );

  // Incoming bit appended MSB-first to the command and payload shifters.
  assign cmd_shift_c    = {cmd_q, mosi_s};
  assign sr_shift_c     = {sr_q, mosi_s};
  assign payload_last_c = (kind_q == PL_VIEW) ? (cnt_q == CNT_W'(VIEW_LEN - 1))
                                              : (cnt_q == CNT_W'(COLOUR_BITS - 1));
  // A transaction counts only when its final bit lands while select is still low.
  assign complete_c     = (state_q == ST_PAYLOAD) && sclk_rise && payload_last_c && !ss_rise;
  assign view_done_c    = complete_c && (kind_q == PL_VIEW);

  // Receive FSM: command byte, exact-length payload, then ignore until select rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kind_q  <= PL_VIEW;
      cnt_q   <= '0;
      cmd_q   <= '0;
      sr_q    <= '0;
    end else if (ss_rise) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_fall) begin
            state_q <= ST_CMD;
            cnt_q   <= '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            cmd_q <= cmd_shift_c[CMD_BITS-2:0];
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
              cnt_q <= '0;
              if (cmd_shift_c == CMD_VIEW) begin
                state_q <= ST_PAYLOAD;
                kind_q  <= PL_VIEW;
              end
`ifdef SPI_COLOUR_REGS_EN
              else if (cmd_shift_c == CMD_COLOUR) begin
                state_q <= ST_PAYLOAD;
                kind_q  <= PL_COLOUR;
              end
`endif
              else begin
                state_q <= ST_DONE;
              end
            end
          end
        end
        ST_PAYLOAD: begin
          if (sclk_rise) begin
            sr_q  <= sr_shift_c[SR_W-2:0];
            cnt_q <= cnt_q + CNT_W'(1);
            if (payload_last_c) begin
              state_q <= ST_DONE;
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  // View shadow: a completion always wins over a same-cycle commit clear, so data
  // arriving alongside load_if_ready stays pending for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      view_shadow_q <= '0;
      view_pend_q   <= 1'b0;
    end else begin
      if (load_if_ready && view_pend_q) begin
        view_pend_q <= 1'b0;
      end
      if (view_done_c) begin
        view_shadow_q <= sr_shift_c;
        view_pend_q   <= 1'b1;
      end
    end
  end

  // Live view vectors change only on a commit of a pending view set.
  always_ff @(posedge clk) begin
    if (reset) begin
      playerX <= FW'(RST_PLAYER_X);
      playerY <= FW'(RST_PLAYER_Y);
      facingX <= FW'(RST_FACING_X);
      facingY <= FW'(RST_FACING_Y);
      vplaneX <= FW'(RST_VPLANE_X);
      vplaneY <= FW'(RST_VPLANE_Y);
    end else if (load_if_ready && view_pend_q) begin
      playerX <= view_shadow_q[VIEW_LEN-1 -: FW];
      playerY <= view_shadow_q[VIEW_LEN-1-FW -: FW];
      facingX <= view_shadow_q[VIEW_LEN-1-2*FW -: FW];
      facingY <= view_shadow_q[VIEW_LEN-1-3*FW -: FW];
      vplaneX <= view_shadow_q[VIEW_LEN-1-4*FW -: FW];
      vplaneY <= view_shadow_q[FW-1:0];
    end
  end

`ifdef SPI_COLOUR_REGS_EN
  colour_t col_shadow_q;
  logic    col_pend_q;
  logic    col_done_c;

  assign col_done_c = complete_c && (kind_q == PL_COLOUR);
  assign any_pend_c = view_pend_q || col_pend_q;

  // Colour shadow, same pending/overwrite rules as the view set.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_shadow_q <= '{sky: RST_SKY, flr: RST_FLOOR};
      col_pend_q   <= 1'b0;
    end else begin
      if (load_if_ready && col_pend_q) begin
        col_pend_q <= 1'b0;
      end
      if (col_done_c) begin
        col_shadow_q <= colour_t'(sr_shift_c[COLOUR_BITS-1:0]);
        col_pend_q   <= 1'b1;
      end
    end
  end

  // Live colours change only on a commit of a pending colour set.
  always_ff @(posedge clk) begin
    if (reset) begin
      sky_rgb   <= RST_SKY;
      floor_rgb <= RST_FLOOR;
    end else if (load_if_ready && col_pend_q) begin
      sky_rgb   <= col_shadow_q.sky;
      floor_rgb <= col_shadow_q.flr;
    end
  end
`else
  assign any_pend_c = view_pend_q;
  assign sky_rgb    = RST_SKY;
  assign floor_rgb  = RST_FLOOR;
`endif

  // Status: commit strobe and bus-activity flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_loaded <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_loaded <= load_if_ready && any_pend_c;
      o_busy   <= ~ss_n_s;
    end
  end

endmodule

// File: tb/tb_spi_cmd_regs.sv
// tb_spi_cmd_regs: directed SPI transactions; expected live register sets are queued
// when a commit is requested and checked by a monitor whenever o_loaded pulses.
module tb_spi_cmd_regs;

  localparam int unsigned FW = 16;

  typedef struct packed {
    logic [15:0] px;
    logic [15:0] py;
    logic [15:0] fx;
    logic [15:0] fy;
    logic [15:0] vx;
    logic [15:0] vy;
    logic [5:0]  sky;
    logic [5:0]  flr;
  } regs_t;

  logic          clk;
  logic          reset;
  logic          i_sclk;
  logic          i_mosi;
  logic          i_ss_n;
  logic          load_if_ready;
  logic [FW-1:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic [5:0]    sky_rgb, floor_rgb;
  logic          o_loaded;
  logic          o_busy;

  regs_t exp_q[$];
  regs_t cur_exp;
  regs_t rst_v;
  regs_t prev_act;
  regs_t mon_e;
  int    n_checks;
  int    n_errors;
  int    loads_seen;
  int    loads_exp;

  spi_cmd_regs #(.FW(FW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_sclk        (i_sclk),
    .i_mosi        (i_mosi),
    .i_ss_n        (i_ss_n),
    .load_if_ready (load_if_ready),
    .playerX       (playerX),
    .playerY       (playerY),
    .facingX       (facingX),
    .facingY       (facingY),
    .vplaneX       (vplaneX),
    .vplaneY       (vplaneY),
    .sky_rgb       (sky_rgb),
    .floor_rgb     (floor_rgb),
    .o_loaded      (o_loaded),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic regs_t act();
    return {playerX, playerY, facingX, facingY, vplaneX, vplaneY, sky_rgb, floor_rgb};
  endfunction

  function automatic regs_t mk(input logic [15:0] px, input logic [15:0] py,
                               input logic [15:0] fx, input logic [15:0] fy,
                               input logic [15:0] vx, input logic [15:0] vy,
                               input logic [5:0] sky, input logic [5:0] flr);
    regs_t r;
    r.px = px; r.py = py; r.fx = fx; r.fy = fy;
    r.vx = vx; r.vy = vy; r.sky = sky; r.flr = flr;
    return r;
  endfunction

  function automatic logic [95:0] vbits(input regs_t t);
    return {t.px, t.py, t.fx, t.fy, t.vx, t.vy};
  endfunction

  task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, a, e);
    end
  endtask

  // Monitor: every o_loaded pulse must match the oldest queued set; otherwise outputs hold.
  always @(negedge clk) begin
    if (reset) begin
      prev_act = act();
    end else begin
      if (o_loaded) begin
        loads_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_load", 128'(1), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("commit_regs", 128'(act()), 128'(mon_e));
        end
      end else begin
        check("stable_outputs", 128'(act()), 128'(prev_act));
      end
      prev_act = act();
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_exp = rst_v;
  endtask

  task automatic ss_low();
    @(negedge clk);
    i_ss_n = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_high", 128'(o_busy), 128'(1));
  endtask

  task automatic ss_high();
    repeat (4) @(negedge clk);
    i_ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_low", 128'(o_busy), 128'(0));
  endtask

  // One mode-0 bit: data set while sclk low, sclk high for 4 clocks (sclk = clk/8).
  // With coincide set, load_if_ready is timed to the clock in which the DUT takes this
  // bit: 2 synchroniser flops + 1 edge-pulse register after the sclk rise.
  task automatic send_bit(input logic b, input bit coincide);
    i_mosi = b;
    repeat (4) @(negedge clk);
    i_sclk = 1'b1;
    repeat (3) @(negedge clk);
    if (coincide) load_if_ready = 1'b1;
    @(negedge clk);
    load_if_ready = 1'b0;
    i_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [127:0] v, input int n, input bit coincide_last);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], coincide_last && (i == 0));
  endtask

  task automatic send_view(input regs_t t, input bit coincide_last);
    ss_low();
    send_bits(128'(8'h00), 8, 1'b0);
    send_bits(128'(vbits(t)), 96, coincide_last);
    ss_high();
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_if_ready = 1'b1;
    @(negedge clk);
    load_if_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_and_load(input string name, input regs_t t);
    exp_q.push_back(t);
    loads_exp++;
    cur_exp = t;
    pulse_load();
    check(name, 128'(act()), 128'(cur_exp));
  endtask

  task automatic load_none(input string name);
    pulse_load();
    check(name, 128'(act()), 128'(cur_exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    regs_t t1, t2, t3, t4, t5, t6, t7, t8;
    n_checks = 0; n_errors = 0; loads_seen = 0; loads_exp = 0;
    reset = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0; i_ss_n = 1'b1; load_if_ready = 1'b0;
    rst_v = mk(16'h0300, 16'h0300, 16'h0000, 16'h0200, 16'hFF00, 16'h0000, 6'b010101, 6'b101010);
    cur_exp = rst_v;
    prev_act = rst_v;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_regs", 128'(act()), 128'(rst_v));
    check("reset_loaded", 128'(o_loaded), 128'(0));
    check("reset_busy", 128'(o_busy), 128'(0));

    // Full view transaction then commit.
    t1 = mk(16'h0480, 16'h0500, 16'h0200, 16'h0000, 16'h0000, 16'h0100, 6'b010101, 6'b101010);
    send_view(t1, 1'b0);
    check("no_commit_before_load", 128'(act()), 128'(rst_v));
    push_and_load("view_commit", t1);

    // Partial transaction (40 payload bits) is discarded.
    do_reset();
    ss_low();
    send_bits(128'(8'h00), 8, 1'b0);
    send_bits(128'(40'hA5_5A_C3_3C_F0), 40, 1'b0);
    ss_high();
    load_none("partial_discard");

    // Newer complete transaction overwrites pending data.
    t2 = mk(16'h0100, 16'h0111, 16'h0122, 16'h0133, 16'h0144, 16'h0155, 6'b010101, 6'b101010);
    t3 = mk(16'h0200, 16'h0211, 16'h0222, 16'h0233, 16'h0244, 16'h0255, 6'b010101, 6'b101010);
    send_view(t2, 1'b0);
    send_view(t3, 1'b0);
    push_and_load("overwrite_pending", t3);

    // Completion coincides with load and nothing older pending: stays pending.
    t4 = mk(16'h1234, 16'hFEDC, 16'h8001, 16'h7FFE, 16'h00FF, 16'hFF00, 6'b010101, 6'b101010);
    send_view(t4, 1'b1);
    check("coincide_no_change", 128'(act()), 128'(cur_exp));
    push_and_load("coincide_next_load", t4);

    // Extra bits after a complete payload are ignored.
    t5 = mk(16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3, 6'b010101, 6'b101010);
    ss_low();
    send_bits(128'(8'h00), 8, 1'b0);
    send_bits(128'(vbits(t5)), 96, 1'b0);
    send_bits(128'(8'h0F), 8, 1'b0);
    ss_high();
    push_and_load("extra_bits_ignored", t5);

    // Unknown command discards its payload.
    t6 = mk(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 6'b010101, 6'b101010);
    ss_low();
    send_bits(128'(8'h05), 8, 1'b0);
    send_bits(128'(vbits(t6)), 96, 1'b0);
    ss_high();
    load_none("unknown_cmd");

    // Colour command.
    ss_low();
    send_bits(128'(8'h01), 8, 1'b0);
    send_bits(128'({6'h3F, 6'h00}), 12, 1'b0);
    ss_high();
`ifdef SPI_COLOUR_REGS_EN
    t7 = cur_exp;
    t7.sky = 6'h3F;
    t7.flr = 6'h00;
    push_and_load("colour_commit", t7);
`else
    t7 = cur_exp;
    load_none("colour_disabled");
    check("colour_unchanged", 128'({sky_rgb, floor_rgb}), 128'({t7.sky, t7.flr}));
`endif

    // Reset mid-payload; later bits (including a well-formed frame) ignored until ss_n high.
    ss_low();
    send_bits(128'(8'h00), 8, 1'b0);
    send_bits(128'(vbits(t6) >> 66), 30, 1'b0);
    do_reset();
    send_bits(128'(vbits(t6)), 66, 1'b0);
    send_bits(128'(8'h00), 8, 1'b0);
    send_bits(128'(vbits(t6)), 96, 1'b0);
    ss_high();
    load_none("reset_abort");
    check("reset_abort_regs", 128'(act()), 128'(rst_v));

    // Receiver is usable again after the aborted transaction.
    t8 = mk(16'h0042, 16'h0084, 16'h0000, 16'h0200, 16'hFE00, 16'h0000, 6'b010101, 6'b101010);
    send_view(t8, 1'b0);
    push_and_load("post_reset_commit", t8);

    repeat (4) @(negedge clk);
    check("load_count", 128'(loads_seen), 128'(loads_exp));
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
